// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/uart handshake bundle between the source FIFOs, the arbiter and the uart core
interface uart_tx_arbiter_if #(
  parameter int N_REQ   = 2,
  parameter int GRANT_W = 1
);
  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_lock;
  logic [N_REQ-1:0]   req_ready;
  logic [7:0]         tx_byte;
  logic               tx_start;
  logic               tx_busy;
  logic [GRANT_W-1:0] grant_id;
  logic               idle;

  // master: the arbiter, which owns the uart transmit side
  modport master (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_byte, tx_start, grant_id, idle
  );

  modport slave (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_byte, tx_start, grant_id, idle
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one uart transmitter, one byte per grant
// Define UART_ARB_LOCK_EN to let a locked requester keep the grant for contiguous messages.
module uart_tx_arbiter #(
  parameter int N_REQ   = 2,
  parameter int GRANT_W = 1
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_SETTLE, S_DRAIN} state_t;

  state_t             state_q, state_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_q, rr_d;
  logic [GRANT_W-1:0] win, grant_w;
  logic [N_REQ-1:0]   ready_q, ready_d;
  logic               start_q, start_d;
  logic               idle_q, idle_d;
  logic               found, do_grant;
  logic               lock_hold_q, lock_hold_d;
  logic [3:0]         hold_cnt_q, hold_cnt_d;

  // Lowest rotated offset from start wins; returns {found, index}.
  function automatic logic [GRANT_W:0] rr_search(input logic [N_REQ-1:0] valid,
                                                 input logic [GRANT_W-1:0] start);
    logic [GRANT_W:0] res;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (valid[j] && ((j == int'(start) + i) || (j == int'(start) + i - N_REQ)))
          res = {1'b1, GRANT_W'(j)};
      end
    end
    return res;
  endfunction

  assign {found, win} = rr_search(bus.req_valid, rr_q);

`ifdef UART_ARB_LOCK_EN
  logic lock_cur, valid_cur;

  always_comb begin
    lock_cur  = 1'b0;
    valid_cur = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (GRANT_W'(j) == grant_q) begin
        lock_cur  = bus.req_lock[j];
        valid_cur = bus.req_valid[j];
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^{bus.req_lock, lock_hold_q, hold_cnt_q};
`endif

  always_comb begin
    state_d     = state_q;
    tx_byte_d   = tx_byte_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    ready_d     = '0;
    start_d     = 1'b0;
    lock_hold_d = lock_hold_q;
    hold_cnt_d  = hold_cnt_q;
    do_grant    = 1'b0;
    grant_w     = win;

    case (state_q)
      S_IDLE: begin
`ifdef UART_ARB_LOCK_EN
        // A locked owner gets 16 idle cycles to refill before round robin resumes.
        if (lock_hold_q) begin
          if (lock_cur && valid_cur && !bus.tx_busy) begin
            do_grant = 1'b1;
            grant_w  = grant_q;
          end else if (!lock_cur || hold_cnt_q == 4'd15) begin
            lock_hold_d = 1'b0;
            hold_cnt_d  = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end else
`endif
        if (found && !bus.tx_busy) do_grant = 1'b1;
      end
      S_LOAD: begin
        state_d = S_START;
        start_d = 1'b1;
      end
      S_START:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_DRAIN;
      S_DRAIN: begin
        if (!bus.tx_busy) begin
`ifdef UART_ARB_LOCK_EN
          if (lock_cur && valid_cur) begin
            do_grant = 1'b1;
            grant_w  = grant_q;
          end else if (lock_cur) begin
            state_d     = S_IDLE;
            lock_hold_d = 1'b1;
            hold_cnt_d  = '0;
          end else
`endif
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_grant) begin
      state_d     = S_LOAD;
      grant_d     = grant_w;
      rr_d        = (grant_w == GRANT_W'(N_REQ - 1)) ? '0 : grant_w + 1'b1;
      lock_hold_d = 1'b0;
      hold_cnt_d  = '0;
      for (int j = 0; j < N_REQ; j++) begin
        if (GRANT_W'(j) == grant_w) begin
          tx_byte_d  = bus.req_data[8*j +: 8];
          ready_d[j] = 1'b1;
        end
      end
    end

    idle_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tx_byte_q   <= 8'h00;
      grant_q     <= '0;
      rr_q        <= '0;
      ready_q     <= '0;
      start_q     <= 1'b0;
      idle_q      <= 1'b1;
      lock_hold_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      tx_byte_q   <= tx_byte_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      ready_q     <= ready_d;
      start_q     <= start_d;
      idle_q      <= idle_d;
      lock_hold_q <= lock_hold_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.tx_byte   = tx_byte_q;
  assign bus.tx_start  = start_q;
  assign bus.grant_id  = grant_q;
  assign bus.idle      = idle_q;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ready_q));
  a_ready_in_load: assert property (@(posedge clk) disable iff (rst) (ready_q != '0) == (state_q == S_LOAD));
  a_start_in_start: assert property (@(posedge clk) disable iff (rst) start_q == (state_q == S_START));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench with a round-robin scoreboard and a busy-counting uart model
module tb_uart_tx_arbiter;
  localparam int N_REQ    = 2;
  localparam int GRANT_W  = 1;
  localparam int BUSY_LEN = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N_REQ), .GRANT_W(GRANT_W)) bus ();
  uart_tx_arbiter #(.N_REQ(N_REQ), .GRANT_W(GRANT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Requester FIFOs and uart model
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       lock0        = 1'b0;
  logic       foreign_busy = 1'b0;
  int         uart_cnt     = 0;

  assign bus.tx_busy = (uart_cnt != 0) || foreign_busy;

  always @(posedge clk) begin
    if (bus.tx_start) uart_cnt <= BUSY_LEN;
    else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
  end

  always @(posedge clk) begin
    logic [1:0]  v;
    logic [15:0] d;
    if (bus.req_ready[0] && q0.size() > 0) void'(q0.pop_front());
    if (bus.req_ready[1] && q1.size() > 0) void'(q1.pop_front());
    #1;
    v = {q1.size() != 0, q0.size() != 0};
    d = {(q1.size() != 0) ? q1[0] : 8'h00, (q0.size() != 0) ? q0[0] : 8'h00};
    bus.req_valid = v;
    bus.req_data  = d;
    bus.req_lock  = {1'b0, lock0};
  end

  // Scoreboard: who must win from the previous-edge inputs, and what the uart must see
  logic [7:0]       uart_log[$];
  logic [N_REQ-1:0] p_valid = '0;
  logic [15:0]      p_data  = '0;
  logic             p_busy  = 1'b0;
  logic             p_rst   = 1'b1;
  int               m_rr    = 0;
  logic             pend    = 1'b0;
  logic [7:0]       pend_byte = 8'h00;
  logic             chk_rr  = 1'b1;

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int rr);
    for (int k = 0; k < N_REQ; k++)
      if (v[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w, wa;
    if (p_rst) begin
      check("rst_ready", bus.req_ready, 0);
      check("rst_start", bus.tx_start, 0);
      check("rst_idle", bus.idle, 1);
      check("rst_byte", bus.tx_byte, 8'h00);
      check("rst_grant", bus.grant_id, 0);
      m_rr = 0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        check("start_latency", bus.tx_start, 1);
        check("start_byte", bus.tx_byte, pend_byte);
        pend = 1'b0;
      end else begin
        check("no_stray_start", bus.tx_start, 0);
      end
      if (bus.tx_start) uart_log.push_back(bus.tx_byte);
      if (bus.req_ready != '0) begin
        check("ready_onehot", $countones(bus.req_ready), 1);
        check("ready_not_busy", p_busy, 0);
        check("ready_not_idle", bus.idle, 0);
        w = rr_pick(p_valid, m_rr);
        if (chk_rr) check("rr_pick", bus.req_ready, (w < 0) ? 0 : (1 << w));
        wa = bus.req_ready[1] ? 1 : 0;
        check("grant_id", bus.grant_id, wa);
        check("grant_byte", bus.tx_byte, p_data[8*wa +: 8]);
        m_rr      = (wa + 1) % N_REQ;
        pend      = 1'b1;
        pend_byte = p_data[8*wa +: 8];
      end
    end
    p_valid = bus.req_valid;
    p_data  = bus.req_data;
    p_busy  = bus.tx_busy;
    p_rst   = rst;
  end

  task automatic wait_log(input int n, input int budget, input string name);
    int c = 0;
    while (uart_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check(name, uart_log.size() >= n, 1);
  endtask

  task automatic check_log(input string name, input logic [63:0] exp, input int n);
    check(name, uart_log.size(), n);
    for (int i = 0; i < n; i++)
      check(name, (i < uart_log.size()) ? uart_log[i] : 8'hxx, exp[8*i +: 8]);
  endtask

  task automatic settle();
    int c = 0;
    while (!(bus.idle && !bus.tx_busy) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("settle", bus.idle && !bus.tx_busy, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    uart_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cv, cr, cs, ci, nready, c;
    logic [7:0] sb;

    // Reset with both requesters valid
    rst = 1'b1;
    q0.push_back(8'hAA);
    q1.push_back(8'hBB);
    repeat (3) begin
      @(negedge clk);
      check("reset_valid_applied", bus.req_valid, 2'b11);
      check("reset_ready", bus.req_ready, 0);
      check("reset_start", bus.tx_start, 0);
      check("reset_idle", bus.idle, 1);
      check("reset_byte", bus.tx_byte, 8'h00);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wait_log(2, 200, "reset_release_log");
    check_log("reset_release_order", 64'hBBAA, 2);

    // Single byte latency
    settle();
    do_reset();
    q0.push_back(8'h41);
    cv = -1; cr = -1; cs = -1; ci = -1; sb = 8'h00;
    for (int k = 0; k < 100 && ci < 0; k++) begin
      @(negedge clk);
      if (cv < 0 && bus.req_valid[0]) cv = k;
      if (cr < 0 && bus.req_ready[0]) cr = k;
      if (cs < 0 && bus.tx_start) begin
        cs = k;
        sb = bus.tx_byte;
      end
      if (cs >= 0 && ci < 0 && bus.idle) ci = k;
    end
    check("single_ready_lat", cr - cv, 1);
    check("single_start_lat", cs - cv, 2);
    check("single_byte", sb, 8'h41);
    check("single_idle_after_busy", ci - cs, 22);

    // Fairness with both requesters always valid
    settle();
    do_reset();
    q0.push_back(8'h10); q0.push_back(8'h11); q0.push_back(8'h12);
    q1.push_back(8'h20); q1.push_back(8'h21); q1.push_back(8'h22);
    wait_log(6, 400, "fair_log");
    check_log("fair_order", 64'h2212_2111_2010, 6);

    // Foreign transmission blocks the grant
    settle();
    foreign_busy = 1'b1;
    do_reset();
    q1.push_back(8'h55);
    nready = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.req_ready != '0) nready++;
    end
    check("foreign_no_ready", nready, 0);
    @(posedge clk); #1;
    foreign_busy = 1'b0;
    c = 0;
    while (bus.req_ready == '0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check("foreign_ready", bus.req_ready, 2'b10);
    check("foreign_grant_id", bus.grant_id, 1);
    wait_log(1, 50, "foreign_log");
    check_log("foreign_byte", 64'h55, 1);

    // Reset while draining
    settle();
    do_reset();
    q0.push_back(8'h61);
    q0.push_back(8'h62);
    c = 0;
    while (!bus.tx_start && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("drain_first_start", bus.tx_start, 1);
    repeat (5) @(negedge clk);
    check("drain_busy_before_rst", bus.tx_busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drain_rst_idle", bus.idle, 1);
    check("drain_rst_start", bus.tx_start, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_log(2, 200, "drain_log");
    repeat (60) @(negedge clk);
    check_log("drain_order", 64'h6261, 2);

`ifdef UART_ARB_LOCK_EN
    // Locked message stays contiguous, then the lock times out
    settle();
    do_reset();
    chk_rr = 1'b0;
    lock0  = 1'b1;
    q0.push_back(8'hA0); q0.push_back(8'hA1); q0.push_back(8'hA2);
    q1.push_back(8'hB0);
    wait_log(3, 300, "lock_log3");
    ci = 0;
    c  = 0;
    while (bus.req_ready == '0 && c < 100) begin
      @(negedge clk);
      if (bus.idle) ci++;
      c++;
    end
    check("lock_hold_cycles", ci, 17);
    check("lock_release_ready", bus.req_ready, 2'b10);
    wait_log(4, 100, "lock_log4");
    check_log("lock_order", 64'hB0A2_A1A0, 4);
    lock0  = 1'b0;
    settle();
    chk_rr = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
